// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-port arbiter for the single-port data RAM
// Optional macro DATA_RAM_ARB_RR_EN selects round-robin arbitration; fixed A priority otherwise.
module data_ram_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int DELAY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_wren,
  input  logic [7:0]           a_addr,
  input  logic [BIT_WIDTH-1:0] a_data,
  input  logic                 a_isSigned,
  input  logic [1:0]           a_dataSize,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [BIT_WIDTH-1:0] a_q,
  input  logic                 b_req,
  input  logic                 b_wren,
  input  logic [7:0]           b_addr,
  input  logic [BIT_WIDTH-1:0] b_data,
  input  logic                 b_isSigned,
  input  logic [1:0]           b_dataSize,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [BIT_WIDTH-1:0] b_q,
  output logic [BIT_WIDTH-1:0] ram_data,
  output logic [7:0]           ram_addr,
  output logic                 ram_wren,
  output logic                 ram_isSigned,
  output logic [1:0]           ram_dataSize,
  input  logic [BIT_WIDTH-1:0] ram_q,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam int CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_winner;  // 1 = port B
  logic          owner;        // 1 = port B
  logic          any_req;
  logic          pick_b;
  logic          grant;

  always_comb begin
    any_req = a_req | b_req;
`ifdef DATA_RAM_ARB_RR_EN
    pick_b  = b_req & (~a_req | ~last_winner);
`else
    pick_b  = b_req & ~a_req;
`endif
    // gnt is gated by rst so that every output reads 0 while reset is held
    grant   = (state == S_IDLE) & any_req & ~rst;
  end

  assign a_gnt = grant & ~pick_b;
  assign b_gnt = grant & pick_b;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_winner  <= 1'b1;
      owner        <= 1'b0;
      ram_data     <= '0;
      ram_addr     <= '0;
      ram_wren     <= 1'b0;
      ram_isSigned <= 1'b0;
      ram_dataSize <= 2'd0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          ram_wren <= 1'b0;
          if (any_req) begin
            ram_addr     <= pick_b ? b_addr     : a_addr;
            ram_data     <= pick_b ? b_data     : a_data;
            ram_wren     <= pick_b ? b_wren     : a_wren;
            ram_isSigned <= pick_b ? b_isSigned : a_isSigned;
            ram_dataSize <= pick_b ? b_dataSize : a_dataSize;
            owner        <= pick_b;
            last_winner  <= pick_b;
            state        <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // ram_wren still holds the captured store flag during this cycle
          ram_wren <= 1'b0;
          if (ram_wren) begin
            state <= S_IDLE;
          end else if (DELAY == 0) begin
            state <= S_CAPTURE;
          end else begin
            cnt   <= CW'(DELAY);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (owner) begin
            b_q      <= ram_q;
            b_rvalid <= 1'b1;
          end else begin
            a_q      <= ram_q;
            a_rvalid <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed and randomized self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;

  localparam int BW     = 32;
  localparam int DELAY  = 2;
  localparam int RD_LAT = DELAY + 1;

  logic clk, rst;
  logic a_req, a_wren, a_isSigned, a_gnt, a_rvalid;
  logic b_req, b_wren, b_isSigned, b_gnt, b_rvalid;
  logic [7:0] a_addr, b_addr, ram_addr;
  logic [BW-1:0] a_data, b_data, a_q, b_q, ram_data, ram_q;
  logic [1:0] a_dataSize, b_dataSize, ram_dataSize;
  logic ram_wren, ram_isSigned, busy;
  logic init_mem;

  data_ram_arbiter #(.BIT_WIDTH(BW), .DELAY(DELAY)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data),
    .a_isSigned(a_isSigned), .a_dataSize(a_dataSize),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_q(a_q),
    .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_data(b_data),
    .b_isSigned(b_isSigned), .b_dataSize(b_dataSize),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_q(b_q),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_isSigned(ram_isSigned), .ram_dataSize(ram_dataSize),
    .ram_q(ram_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  // RAM stand-in with RD_LAT cycles of read latency
  logic [BW-1:0] mem  [256];
  logic [BW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RD_LAT-1];

  // reference model state
  logic [31:0] shadow [256];
  logic        model_last_b;
  logic [31:0] exp_a_q, exp_b_q;
  int pass_cnt = 0;
  int total    = 0;

  function automatic logic model_pick_b(input logic ar, input logic br);
    if (ar && br) begin
`ifdef DATA_RAM_ARB_RR_EN
      return !model_last_b;
`else
      return 1'b0;
`endif
    end
    return br;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_a(input logic w, input logic [7:0] ad, input logic [31:0] d,
                       input logic s, input logic [1:0] sz);
    a_req = 1'b1; a_wren = w; a_addr = ad; a_data = d; a_isSigned = s; a_dataSize = sz;
  endtask

  task automatic set_b(input logic w, input logic [7:0] ad, input logic [31:0] d,
                       input logic s, input logic [1:0] sz);
    b_req = 1'b1; b_wren = w; b_addr = ad; b_data = d; b_isSigned = s; b_dataSize = sz;
  endtask

  task automatic wait_gnt();
    for (int k = 0; k < 20; k++) begin
      smp();
      if (a_gnt || b_gnt) break;
      nc();
    end
    check("gnt_seen", 32'(a_gnt | b_gnt), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ram_data"}, ram_data, 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
    check({tag, "_ram_sgn"}, 32'(ram_isSigned), 32'd0);
    check({tag, "_ram_size"}, 32'(ram_dataSize), 32'd0);
    check({tag, "_gnts"}, 32'({a_gnt, b_gnt}), 32'd0);
    check({tag, "_rvalids"}, 32'({a_rvalid, b_rvalid}), 32'd0);
    check({tag, "_a_q"}, a_q, 32'd0);
    check({tag, "_b_q"}, b_q, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called at the sample point of the grant cycle; returns at the sample point of the last cycle.
  task automatic follow(input logic is_b, input logic w, input logic [7:0] ad,
                        input logic [31:0] d, input logic s, input logic [1:0] sz);
    logic [31:0] expq;
    nc();
    a_req = 1'b0; b_req = 1'b0;
    smp();
    check("c1_addr", 32'(ram_addr), 32'(ad));
    check("c1_size", 32'(ram_dataSize), 32'(sz));
    check("c1_sgn", 32'(ram_isSigned), 32'(s));
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_wren", 32'(ram_wren), 32'(w));
    if (w) begin
      check("st_data", ram_data, d);
      check("st_c1_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
      shadow[ad] = d;
      nc();
      smp();
      check("st_c2_wren", 32'(ram_wren), 32'd0);
      check("st_c2_busy", 32'(busy), 32'd0);
      check("st_c2_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    end else begin
      for (int k = 2; k <= RD_LAT + 1; k++) begin
        nc();
        smp();
        check("ld_addr_stable", 32'(ram_addr), 32'(ad));
        check("ld_no_wren", 32'(ram_wren), 32'd0);
        check("ld_early_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        check("ld_busy", 32'(busy), 32'd1);
      end
      nc();
      smp();
      expq = shadow[ad];
      if (is_b) begin
        check("ld_b_rvalid", 32'({a_rvalid, b_rvalid}), 32'd1);
        check("ld_b_q", b_q, expq);
        check("ld_a_q_kept", a_q, exp_a_q);
        exp_b_q = expq;
      end else begin
        check("ld_a_rvalid", 32'({a_rvalid, b_rvalid}), 32'd2);
        check("ld_a_q", a_q, expq);
        check("ld_b_q_kept", b_q, exp_b_q);
        exp_a_q = expq;
      end
      check("ld_end_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int ng, nb, exp_nb, prev, cyc, bg, wc, rv, g2, gn;
    logic eb;
    logic [1:0] m;
    logic [7:0] ra, rb_addr;
    logic [31:0] rd, rbd;
    logic rw, rbw, rs, rbs;
    logic [1:0] rz, rbz;

    rst = 1'b1; init_mem = 1'b1;
    a_req = 1'b0; a_wren = 1'b0; a_addr = '0; a_data = '0; a_isSigned = 1'b0; a_dataSize = '0;
    b_req = 1'b0; b_wren = 1'b0; b_addr = '0; b_data = '0; b_isSigned = 1'b0; b_dataSize = '0;
    for (int i = 0; i < 256; i++) shadow[i] = seed(i);
    model_last_b = 1'b1; exp_a_q = '0; exp_b_q = '0;
    nc();
    a_req = 1'b1;
    nc();
    smp();
    check_zero("reset");
    nc();
    a_req = 1'b0; rst = 1'b0; init_mem = 1'b0;
    smp();

    // A store, then B load of the same word
    nc();
    set_a(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 2'd2);
    wait_gnt();
    check("t1_a_gnt", 32'({a_gnt, b_gnt}), 32'd2);
    model_last_b = 1'b0;
    follow(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 2'd2);

    nc();
    set_b(1'b0, 8'h10, 32'h0, 1'b1, 2'd2);
    wait_gnt();
    check("t2_b_gnt", 32'({a_gnt, b_gnt}), 32'd1);
    model_last_b = 1'b1;
    follow(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 2'd2);

    // both ports hold load requests across four grants
    nc();
    set_a(1'b0, 8'h10, 32'h0, 1'b0, 2'd2);
    set_b(1'b0, 8'h10, 32'h0, 1'b0, 2'd2);
    ng = 0; nb = 0; exp_nb = 0; prev = -1; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      smp();
      if (b_gnt) nb++;
      if (a_gnt || b_gnt) begin
        eb = model_pick_b(1'b1, 1'b1);
        check("held_one_gnt", 32'(a_gnt & b_gnt), 32'd0);
        check("held_order_b", 32'(b_gnt), 32'(eb));
        if (prev >= 0) check("held_gap", 32'(cyc - prev), 32'(RD_LAT + 2));
        prev = cyc;
        model_last_b = eb;
        if (eb) exp_nb++;
        ng++;
      end
      if (ng < 4) begin
        nc();
        cyc++;
      end
    end
    check("held_grants", 32'(ng), 32'd4);
    nc();
    a_req = 1'b0; b_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      smp();
      if (!busy) break;
      nc();
    end
    check("held_idle", 32'(busy), 32'd0);
    check("held_b_gnt_count", 32'(nb), 32'(exp_nb));
    exp_a_q = shadow[8'h10];
    if (exp_nb > 0) exp_b_q = shadow[8'h10];
    check("held_a_q", a_q, exp_a_q);
    check("held_b_q", b_q, exp_b_q);

    // B request raised only while busy, then dropped
    nc();
    set_a(1'b0, 8'h20, 32'h0, 1'b0, 2'd2);
    wait_gnt();
    check("t4_a_gnt", 32'({a_gnt, b_gnt}), 32'd2);
    model_last_b = 1'b0;
    nc();
    a_req = 1'b0;
    set_b(1'b1, 8'h77, 32'h12345678, 1'b0, 2'd2);
    smp();
    check("t4_busy", 32'(busy), 32'd1);
    bg = 0; wc = 0; rv = 0;
    nc();
    b_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      bg += int'(b_gnt); wc += int'(ram_wren); rv += int'(a_rvalid);
      nc();
    end
    smp();
    check("drop_b_gnt", 32'(bg), 32'd0);
    check("drop_wren", 32'(wc), 32'd0);
    check("drop_a_rvalid", 32'(rv), 32'd1);
    check("drop_ram_addr", 32'(ram_addr), 32'h20);
    exp_a_q = shadow[8'h20];
    check("drop_a_q", a_q, exp_a_q);

    // reset during WAIT
    nc();
    set_a(1'b0, 8'h30, 32'h0, 1'b0, 2'd2);
    wait_gnt();
    nc();
    a_req = 1'b0;
    smp();
    nc();
    smp();
    check("t5_wait_busy", 32'(busy), 32'd1);
    nc();
    rst = 1'b1;
    set_a(1'b1, 8'h31, 32'h31313131, 1'b0, 2'd2);
    #1;
    check_zero("midrst");
    exp_a_q = '0; exp_b_q = '0; model_last_b = 1'b1;
    nc();
    rst = 1'b0;
    smp();
    check("post_rst_gnt", 32'({a_gnt, b_gnt}), 32'd2);
    model_last_b = 1'b0;
    follow(1'b0, 1'b1, 8'h31, 32'h31313131, 1'b0, 2'd2);
    for (int k = 0; k < 4; k++) begin
      nc();
      smp();
      check("post_rst_no_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    end

    // back-to-back stores with req held
    nc();
    set_a(1'b1, 8'h01, 32'h0101_CAFE, 1'b0, 2'd2);
    wait_gnt();
    check("b2b_first_gnt", 32'(a_gnt), 32'd1);
    gn = 1; g2 = -1; wc = 0;
    for (int c = 1; c <= 8; c++) begin
      nc();
      if (c == 1) begin a_addr = 8'h02; a_data = 32'h0202_BEEF; end
      if (gn == 2 && c == g2 + 1) a_req = 1'b0;
      smp();
      if (a_gnt) begin gn++; if (g2 < 0) g2 = c; end
      if (ram_wren) begin
        wc++;
        check("b2b_wdata", ram_data, (ram_addr == 8'h01) ? 32'h0101_CAFE : 32'h0202_BEEF);
      end
    end
    check("b2b_gnt_gap", 32'(g2), 32'd2);
    check("b2b_gnt_count", 32'(gn), 32'd2);
    check("b2b_wren_cycles", 32'(wc), 32'd2);
    shadow[8'h01] = 32'h0101_CAFE;
    shadow[8'h02] = 32'h0202_BEEF;

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      nc();
      if ($urandom_range(0, 3) == 0) begin
        smp();
        check("rnd_idle", 32'({busy, a_gnt, b_gnt}), 32'd0);
        nc();
      end
      m = 2'($urandom_range(1, 3));
      rw = 1'($urandom); ra = 8'($urandom); rd = $urandom; rs = 1'($urandom); rz = 2'($urandom_range(0, 2));
      rbw = 1'($urandom); rb_addr = 8'($urandom); rbd = $urandom; rbs = 1'($urandom); rbz = 2'($urandom_range(0, 2));
      if (m[0]) set_a(rw, ra, rd, rs, rz);
      if (m[1]) set_b(rbw, rb_addr, rbd, rbs, rbz);
      eb = model_pick_b(m[0], m[1]);
      wait_gnt();
      check("rnd_winner", 32'({a_gnt, b_gnt}), eb ? 32'd1 : 32'd2);
      model_last_b = eb;
      if (eb) follow(1'b1, rbw, rb_addr, rbd, rbs, rbz);
      else    follow(1'b0, rw, ra, rd, rs, rz);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
